// File: rtl/ex_shift_unit.sv
// rtl/ex_shift_unit.sv - execute-stage ARM shifter operand and carry-out register
// Optional macro REGSHIFT_STALL_EN: register-amount shifts take an extra SHIFT cycle.
module ex_shift_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        StallE,
   input  logic        FlushE,
   input  logic        ValidD,
   input  logic [31:0] InstrD,
   input  logic [31:0] RotImmD,
   input  logic [31:0] RmD,
   input  logic [31:0] RsD,
   input  logic        CarryInD,
   output logic [31:0] SrcBE,
   output logic        ShifterCarryE,
   output logic        ValidE,
   output logic        StallShiftD
);

`ifdef REGSHIFT_STALL_EN
   localparam logic STALL_EN = 1'b1;
`else
   localparam logic STALL_EN = 1'b0;
`endif

   typedef enum logic {IDLE, SHIFT} state_t;
   state_t state, state_n;

   // Returns {carry, result}; n is the full 8-bit register amount.
   function automatic logic [32:0] core_shift(input logic [31:0] rm, input logic [7:0] n,
                                              input logic [1:0] typ, input logic cin);
      logic [32:0] t;
      logic [32:0] w;
      logic [63:0] rr;
      logic [5:0]  m;
      t  = {cin, rm};
      m  = (n > 8'd32) ? 6'd32 : n[5:0];
      w  = '0;
      rr = '0;
      if (n != 8'd0) begin
         case (typ)
            2'b00: begin
               t = {1'b0, rm} << m;
               if (n > 8'd32) t = '0;
            end
            2'b01: begin
               w = {rm, 1'b0} >> m;
               t = {w[0], w[32:1]};
               if (n > 8'd32) t = '0;
            end
            2'b10: begin
               w = $signed({rm, 1'b0}) >>> m;
               t = {w[0], w[32:1]};
            end
            default: begin
               rr = {rm, rm} >> n[4:0];
               t  = {rr[31], rr[31:0]};
            end
         endcase
      end
      return t;
   endfunction

   logic        is_imm, is_reg;
   logic [1:0]  typ_d;
   logic [4:0]  amt_d;
   logic [32:0] dec_res, reg_res, res_n;
   logic        valid_n, load_lat;
   logic [31:0] rm_q;
   logic [7:0]  n_q;
   logic [1:0]  typ_q;
   logic        cin_q;
   logic        unused_bits;

   assign is_imm = (InstrD[27:25] == 3'b001);
   assign is_reg = (InstrD[27:25] == 3'b000) && InstrD[4] && !InstrD[7];
   assign typ_d  = InstrD[6:5];
   assign amt_d  = InstrD[11:7];
   assign unused_bits = ^{RsD[31:8], InstrD[31:28], InstrD[24:12], InstrD[3:0]};

   // Immediate amount 0 encodes LSR/ASR #32 and RRX.
   always_comb begin
      dec_res = '0;
      if (is_imm)
         dec_res = {(InstrD[11:8] == 4'd0) ? CarryInD : RotImmD[31], RotImmD};
      else if (is_reg)
         dec_res = core_shift(RmD, RsD[7:0], typ_d, CarryInD);
      else if (amt_d == 5'd0 && typ_d == 2'b11)
         dec_res = {RmD[0], CarryInD, RmD[31:1]};
      else if (amt_d == 5'd0 && typ_d != 2'b00)
         dec_res = core_shift(RmD, 8'd32, typ_d, CarryInD);
      else
         dec_res = core_shift(RmD, {3'b000, amt_d}, typ_d, CarryInD);
   end

   assign reg_res = core_shift(rm_q, n_q, typ_q, cin_q);

   always_comb begin
      state_n  = state;
      res_n    = {ShifterCarryE, SrcBE};
      valid_n  = ValidE;
      load_lat = 1'b0;
      if (FlushE) begin
         valid_n = 1'b0;
         state_n = IDLE;
      end else if (!StallE) begin
         case (state)
            IDLE: begin
               if (ValidD && is_reg && STALL_EN) begin
                  valid_n  = 1'b0;
                  load_lat = 1'b1;
                  state_n  = SHIFT;
               end else if (ValidD) begin
                  res_n   = dec_res;
                  valid_n = 1'b1;
               end else begin
                  valid_n = 1'b0;
               end
            end
            default: begin
               res_n   = reg_res;
               valid_n = 1'b1;
               state_n = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         SrcBE         <= '0;
         ShifterCarryE <= 1'b0;
         ValidE        <= 1'b0;
         rm_q          <= '0;
         n_q           <= '0;
         typ_q         <= '0;
         cin_q         <= 1'b0;
      end else begin
         state                  <= state_n;
         {ShifterCarryE, SrcBE} <= res_n;
         ValidE                 <= valid_n;
         if (load_lat) begin
            rm_q  <= RmD;
            n_q   <= RsD[7:0];
            typ_q <= typ_d;
            cin_q <= CarryInD;
         end
      end
   end

   assign StallShiftD = (state == SHIFT) && STALL_EN;

endmodule
